// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    StEmpty   = 2'd0,
    StFilling = 2'd1,
    StArmed   = 2'd2
  } fill_state_e;

  // Fill counter must be able to hold the value pat_w itself.
  function automatic int unsigned fill_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_shift_hist.sv
// History shift register and fill counter, with clear (pattern load) and
// restart (non-overlapping match) controls.
module seq_shift_hist
  import seq_det_pkg::*;
#(
  parameter int unsigned PatW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            shift_i,
  input  logic            bit_i,
  input  logic            restart_i,
  output logic [PatW-1:0] hist_shift_o,
  output logic            full_shift_o,
  output logic            armed_o
);

  localparam int unsigned FillW = fill_width(PatW);
  localparam logic [FillW-1:0] FillMax = FillW'(PatW);

  logic [PatW-1:0]  hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d, fill_shift;
  fill_state_e      state;

  // Post-shift view used by the comparator in the same cycle.
  always_comb begin
    hist_shift_o = {hist_q[PatW-2:0], bit_i};
    fill_shift   = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
    full_shift_o = (fill_shift == FillMax);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i || restart_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = hist_shift_o;
      fill_d = fill_shift;
    end
  end

  always_comb begin
    state = StFilling;
    if (fill_q == '0) begin
      state = StEmpty;
    end else if (fill_q == FillMax) begin
      state = StArmed;
    end
    armed_o = (state == StArmed);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: runtime-loadable pattern, overlapping or
// non-overlapping matching, registered match pulse and saturating counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W     = 4,
  parameter int unsigned      CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1011)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             inp,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             outp,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             outp_q, outp_d;
  logic [PAT_W-1:0] hist_shift;
  logic             full_shift;
  logic             shift_en;
  logic             match;

  // A pattern load discards the incoming bit entirely.
  assign shift_en = in_valid & ~pat_load;
  assign match    = shift_en & full_shift & (hist_shift == pat_q);

  seq_shift_hist #(
    .PatW (PAT_W)
  ) u_hist (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clear_i      (pat_load),
    .shift_i      (shift_en),
    .bit_i        (inp),
    .restart_i    (match & ~overlap),
    .hist_shift_o (hist_shift),
    .full_shift_o (full_shift),
    .armed_o      (armed)
  );

  always_comb begin
    pat_d  = pat_load ? pat_in : pat_q;
    outp_d = match;
    cnt_d  = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= RESET_PAT;
      cnt_q  <= '0;
      outp_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      outp_q <= outp_d;
    end
  end

  assign outp      = outp_q;
  assign match_cnt = cnt_q;

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector, the next generation of our fixed 1-bit sequence FSM. It accepts one serial bit per valid cycle and matches the last PAT_W bits against a runtime-loadable pattern. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits between a serial input stage and status/interrupt logic.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits (2..32)
- CNT_W, 8, match counter width
- RESET_PAT, 4'b1011 (PAT_W bits), pattern value after reset

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  inp is sampled this cycle
- inp  in  1  serial data bit
- pat_load  in  1  load pat_in as the new pattern
- pat_in  in  PAT_W  new pattern; MSB is the earliest bit received
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  in  1  synchronous clear of match_cnt
- outp  out  1  one-cycle match pulse (registered)
- match_cnt  out  CNT_W  saturating count of matches
- armed  out  1  history holds PAT_W valid bits

## Operation
- History register hist[PAT_W-1:0]: on in_valid, hist <= {hist[PAT_W-2:0], inp}. Fill counter fill, width $clog2(PAT_W+1), increments and saturates at PAT_W.
- Fill state machine:
  - EMPTY (fill=0) -> FILLING on in_valid.
  - FILLING -> ARMED when fill reaches PAT_W.
  - ARMED stays ARMED in overlap mode.
  - Non-overlap match: the next fill is 1 if in_valid, otherwise 0 (EMPTY). No history bit at or before the completing bit counts toward a new match.
- Match condition: in_valid, and the post-shift history equals pattern, and the post-shift fill equals PAT_W. Matching on partial history is forbidden.
- A match sets outp <= 1 for the next cycle. If match_cnt < 2^CNT_W-1, match_cnt increments; otherwise it holds at all-ones.
- overlap is sampled at the edge of each match. A mode change affects only subsequent matches.
- pat_load: pattern <= pat_in, hist <= 0, fill <= 0, outp <= 0. match_cnt is untouched.
- Priorities (same cycle):
  - pat_load over in_valid: the bit is discarded, with no shift and no match.
  - cnt_clr over a match increment: match_cnt = 0. outp still pulses.
- in_valid low: hist, fill and pattern hold, and outp <= 0.

## Timing
- Reset (rst low, asynchronous): hist=0, fill=0, pattern=RESET_PAT, outp=0, match_cnt=0, armed=0. Release is synchronous to clk, and the first sample is on the first edge with rst high.
- Latency: outp is high in exactly the cycle after the edge that samples the completing bit. match_cnt updates on that same edge.
- outp is never high for two cycles unless two consecutive valid bits both complete matches (overlap mode only, e.g. pattern all-ones).
- armed is combinational from fill == PAT_W.
- Reset mid-stream: all partial history is lost immediately, and no match pulse is emitted.

## Structure
- Package seq_det_pkg:
  - fill-state encoding constants (EMPTY, FILLING, ARMED)
  - the fill-counter width function
- One sub-module, seq_shift_hist, holds the history shift register, fill counter, and the clear/restart controls.
- The top level contains:
  - the pattern register
  - the comparator
  - the match pulse
  - the counter

## Test plan
- Reset check: hold rst low mid-stream -> outp=0, match_cnt=0, armed=0. After release, stream 1,0,1,1 -> outp pulses once, one cycle after the 4th bit, and match_cnt=1.
- Overlap on: pattern 1011, stream 1,0,1,1,0,1,1 -> two pulses (after bits 4 and 7), match_cnt=2.
- Overlap off: same stream -> one pulse after bit 4 only, match_cnt=1, and armed drops to 0 after the match.
- Partial history: pattern 0000 after reset (hist=0), stream 0,0,0 -> no pulse. 4th 0 -> pulse.
- pat_load with in_valid in the same cycle: load 1100 while inp=1 -> bit ignored and fill=0. Stream 1,1,0,0 -> one pulse.
- Counter, CNT_W=2:
  - 5 matches -> match_cnt saturates at 3.
  - cnt_clr coincident with a match -> match_cnt=0 while outp pulses.
